wb_regfile: RTL and testbench
=============================

# wb_regfile

Architectural register file that sits directly downstream of the 4-bit 2:1 write-back select mux. It stores the mux output on write-back and supplies two combinational read ports to the operand stage. The mux chooses between the ALU result and the load data. A per-register busy scoreboard lets issue logic stall on registers with an outstanding write. Register 0 is hardwired to zero.

## Interface
- DATA_W, 4, register width; equals the write-back mux width
- NREG, 8, number of registers
- ADDR_W, 3, register address width; NREG = 2**ADDR_W

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- wr_en  in  1  write-back strobe
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back data, driven by the write-back select mux output
- set_busy  in  1  issue marks a destination as pending
- busy_addr  in  ADDR_W  register to mark busy
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data (combinational)
- rd_data_b  out  DATA_W  read port B data (combinational)
- rd_busy_a  out  1  port A operand not yet valid
- rd_busy_b  out  1  port B operand not yet valid
- any_busy  out  1  registered OR of all busy bits

## Operation
- Storage: NREG x DATA_W flops plus NREG busy flops.
- Write: on a clk edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - Writes to address 0 are discarded.
- Busy set: on a clk edge with set_busy=1 and busy_addr!=0, busy[busy_addr] <= 1.
  - set_busy to address 0 is ignored.
- Simultaneous set and clear, same address (wr_en and set_busy both high, wr_addr==busy_addr!=0): data is written, and the busy bit ends at 1. Set wins, because issue of a new writer follows retirement of the old one.
- Simultaneous set and clear, different addresses: both take effect independently.
- Read (per port X in {a,b}):
  - rd_addr_X==0: rd_data_X=0 and rd_busy_X=0.
  - Bypass: if wr_en=1 and wr_addr==rd_addr_X!=0, then rd_data_X=wr_data and rd_busy_X=0 in the same cycle.
  - Otherwise rd_data_X=regs[rd_addr_X] and rd_busy_X=busy[rd_addr_X].
- Both ports may read the same address; each gets identical results.
- any_busy is the OR of the busy vector after the current edge's update. Because it is registered, it reflects the state one cycle after the set/clear.

## Timing
- Reset: all regs=0, all busy=0, any_busy=0.
  - Reset overrides wr_en and set_busy in the same cycle.
  - Reset asserted mid-operation discards all pending state on that edge.
- Write latency: 1 edge for storage; 0 cycles to the read ports via bypass.
- Busy-clear latency: 0 cycles to rd_busy via bypass; 1 edge for the stored bit.
- Busy-set latency: 1 edge; rd_busy reflects the set in the cycle after set_busy.
- No combinational path from set_busy or busy_addr to any output.
- No handshake back-pressure: every asserted wr_en/set_busy is accepted on its edge.

## Test plan
- Reset then read all addresses on both ports -> rd_data=0, rd_busy=0, any_busy=0.
- Write 0xA to r3 at cycle 1 -> bypass gives rd_data_a=0xA in cycle 1; stored read (wr_en=0) gives 0xA in cycle 2.
- Write 0xF to r0, then read r0 on both ports -> 0x0. Issue set_busy on r0 -> rd_busy=0, any_busy stays 0.
- set_busy r5 -> rd_busy_b=1 and any_busy=1 the next cycle. Then wr_en r5 with 0x6 -> rd_busy_b=0 in the same cycle; any_busy=0 the next cycle.
- Same edge, wr_en r2=0x9 and set_busy r2 -> the next cycle reads r2=0x9 with rd_busy=1. Repeat with set_busy on r4 instead -> r2 not busy, r4 busy.
- Write r1..r7 with values 1..7 and set busy on r6, then assert reset together with wr_en r1=0xC -> all regs read 0, no busy bits set, any_busy=0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bus bundle between the write-back / issue / operand stages and the register file.
// The master side drives write-back, busy marking and read addresses; the slave returns operands.
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              set_busy;
    logic [ADDR_W-1:0] busy_addr;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              rd_busy_a;
    logic              rd_busy_b;
    logic              any_busy;

    modport master (
        output wr_en, wr_addr, wr_data, set_busy, busy_addr, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, set_busy, busy_addr, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, any_busy
    );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file with write-back bypass, per-register busy scoreboard
// and a hardwired-zero register 0.
module wb_regfile #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned NREG   = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic              r_any_busy;

    logic              w_wr_ok;
    logic              w_set_ok;
    logic [NREG-1:0]   w_busy_next;
    logic [DATA_W-1:0] w_rd_data_a;
    logic [DATA_W-1:0] w_rd_data_b;
    logic              w_rd_busy_a;
    logic              w_rd_busy_b;

    assign w_wr_ok  = bus.wr_en    && (bus.wr_addr   != '0);
    assign w_set_ok = bus.set_busy && (bus.busy_addr != '0);

    // Clear on retirement first so a same-address issue leaves the bit set.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_ok)  w_busy_next[bus.wr_addr]   = 1'b0;
        if (w_set_ok) w_busy_next[bus.busy_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_busy     <= '0;
            r_any_busy <= 1'b0;
        end else begin
            if (w_wr_ok) r_regs[bus.wr_addr] <= bus.wr_data;
            r_busy     <= w_busy_next;
            r_any_busy <= |w_busy_next;
        end
    end

    // Port A: zero register, then same-cycle write-back bypass, then stored state.
    always_comb begin
        w_rd_data_a = '0;
        w_rd_busy_a = 1'b0;
        if (bus.rd_addr_a != '0) begin
            if (w_wr_ok && (bus.wr_addr == bus.rd_addr_a)) begin
                w_rd_data_a = bus.wr_data;
            end else begin
                w_rd_data_a = r_regs[bus.rd_addr_a];
                w_rd_busy_a = r_busy[bus.rd_addr_a];
            end
        end
    end

    always_comb begin
        w_rd_data_b = '0;
        w_rd_busy_b = 1'b0;
        if (bus.rd_addr_b != '0) begin
            if (w_wr_ok && (bus.wr_addr == bus.rd_addr_b)) begin
                w_rd_data_b = bus.wr_data;
            end else begin
                w_rd_data_b = r_regs[bus.rd_addr_b];
                w_rd_busy_b = r_busy[bus.rd_addr_b];
            end
        end
    end

    assign bus.rd_data_a = w_rd_data_a;
    assign bus.rd_data_b = w_rd_data_b;
    assign bus.rd_busy_a = w_rd_busy_a;
    assign bus.rd_busy_b = w_rd_busy_b;
    assign bus.any_busy  = r_any_busy;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;

    wb_regfile_if #(.DATA_W(4), .ADDR_W(3)) bus ();

    wb_regfile #(.DATA_W(4), .NREG(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [3:0] m_regs [8];
    logic       m_busy [8];
    logic       m_any;

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 4'h0;
            m_busy[i] = 1'b0;
        end
        m_any = 1'b0;
    endtask

    // What a read port should return given the model state and the current write-back.
    task automatic exp_read(input logic [2:0] a, output logic [3:0] d, output logic b);
        if (a == 3'd0) begin
            d = 4'h0; b = 1'b0;
        end else if (bus.wr_en && bus.wr_addr == a) begin
            d = bus.wr_data; b = 1'b0;
        end else begin
            d = m_regs[a]; b = m_busy[a];
        end
    endtask

    // Apply inputs shortly after a rising edge and check all outputs before the next edge.
    task automatic cyc(input logic rst, input logic we, input logic [2:0] wa, input logic [3:0] wd,
                       input logic sb, input logic [2:0] ba, input logic [2:0] ra, input logic [2:0] rb);
        logic [3:0] da, db;
        logic       ba_e, bb_e;
        reset         = rst;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        bus.set_busy  = sb;
        bus.busy_addr = ba;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        #3;
        exp_read(ra, da, ba_e);
        exp_read(rb, db, bb_e);
        cmp("rd_data_a", 8'(bus.rd_data_a), 8'(da));
        cmp("rd_busy_a", 8'(bus.rd_busy_a), 8'(ba_e));
        cmp("rd_data_b", 8'(bus.rd_data_b), 8'(db));
        cmp("rd_busy_b", 8'(bus.rd_busy_b), 8'(bb_e));
        cmp("any_busy",  8'(bus.any_busy),  8'(m_any));
    endtask

    // Advance one edge and update the model from the architectural rules.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (bus.wr_en && bus.wr_addr != 3'd0) begin
                m_regs[bus.wr_addr] = bus.wr_data;
                m_busy[bus.wr_addr] = 1'b0;
            end
            if (bus.set_busy && bus.busy_addr != 3'd0) m_busy[bus.busy_addr] = 1'b1;
            m_any = 1'b0;
            for (int i = 0; i < 8; i++) m_any = m_any | m_busy[i];
        end
        #1;
    endtask

    initial begin
        logic [2:0] wa, ba;
        model_reset();
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.set_busy = 1'b0; bus.busy_addr = '0;
        bus.rd_addr_a = '0; bus.rd_addr_b = '0;
        @(posedge clk); #1;

        // Reset state on every address, both ports
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'(i), 3'(7 - i));
            cmp("rst_data_a", 8'(bus.rd_data_a), 8'h00);
            cmp("rst_busy_b", 8'(bus.rd_busy_b), 8'h00);
            tick();
        end

        // Write r3 with bypass, then stored read
        cyc(1'b0, 1'b1, 3'd3, 4'hA, 1'b0, 3'd0, 3'd3, 3'd3);
        cmp("bypass_r3", 8'(bus.rd_data_a), 8'h0A);
        tick();
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd3, 3'd0);
        cmp("stored_r3", 8'(bus.rd_data_a), 8'h0A);
        tick();

        // r0 ignores writes and busy marks
        cyc(1'b0, 1'b1, 3'd0, 4'hF, 1'b0, 3'd0, 3'd0, 3'd0);
        cmp("r0_bypass", 8'(bus.rd_data_a), 8'h00);
        tick();
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 3'd0, 3'd0, 3'd0);
        cmp("r0_data_b", 8'(bus.rd_data_b), 8'h00);
        tick();
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        cmp("r0_busy", 8'(bus.rd_busy_a), 8'h00);
        cmp("r0_any", 8'(bus.any_busy), 8'h00);
        tick();

        // Busy set then cleared by write-back
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 3'd5, 3'd0, 3'd5);
        cmp("r5_busy_same_cycle", 8'(bus.rd_busy_b), 8'h00);
        tick();
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd0, 3'd5);
        cmp("r5_busy", 8'(bus.rd_busy_b), 8'h01);
        cmp("r5_any", 8'(bus.any_busy), 8'h01);
        tick();
        cyc(1'b0, 1'b1, 3'd5, 4'h6, 1'b0, 3'd0, 3'd0, 3'd5);
        cmp("r5_clr_bypass", 8'(bus.rd_busy_b), 8'h00);
        cmp("r5_any_hold", 8'(bus.any_busy), 8'h01);
        tick();
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd5, 3'd5);
        cmp("r5_any_clr", 8'(bus.any_busy), 8'h00);
        cmp("r5_data", 8'(bus.rd_data_a), 8'h06);
        tick();

        // Same-address set and clear: set wins
        cyc(1'b0, 1'b1, 3'd2, 4'h9, 1'b1, 3'd2, 3'd0, 3'd0);
        tick();
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd2, 3'd2);
        cmp("r2_data", 8'(bus.rd_data_a), 8'h09);
        cmp("r2_busy", 8'(bus.rd_busy_b), 8'h01);
        tick();
        // Different addresses: independent
        cyc(1'b0, 1'b1, 3'd2, 4'h9, 1'b1, 3'd4, 3'd0, 3'd0);
        tick();
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'd2, 3'd4);
        cmp("r2_not_busy", 8'(bus.rd_busy_a), 8'h00);
        cmp("r4_busy", 8'(bus.rd_busy_b), 8'h01);
        tick();

        // Fill, mark busy, then reset together with a write
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 1'b1, 3'(i), 4'(i), 1'b0, 3'd0, 3'(i), 3'd0);
            tick();
        end
        cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 3'd6, 3'd6, 3'd7);
        cmp("r7_data", 8'(bus.rd_data_b), 8'h07);
        tick();
        cyc(1'b1, 1'b1, 3'd1, 4'hC, 1'b0, 3'd0, 3'd1, 3'd6);
        tick();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 3'd0, 3'(i), 3'(i));
            cmp("post_rst_data", 8'(bus.rd_data_a), 8'h00);
            cmp("post_rst_busy", 8'(bus.rd_busy_b), 8'h00);
            cmp("post_rst_any", 8'(bus.any_busy), 8'h00);
            tick();
        end

        // Randomized traffic, with frequent address collisions
        for (int n = 0; n < 600; n++) begin
            wa = 3'($urandom_range(0, 7));
            ba = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 59) == 0),
                ($urandom_range(0, 1) == 1), wa, 4'($urandom),
                ($urandom_range(0, 2) == 0), ba,
                ($urandom_range(0, 2) == 0) ? wa : 3'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0) ? ba : 3'($urandom_range(0, 7)));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
